control_unit_pipe: RTL and testbench

CONTROL_UNIT_PIPE -- requirements
Module: control_unit_pipe

---
 rtl/cu_pkg.sv | 86 ++++++++
 rtl/cu_decode.sv | 78 +++++++
 rtl/control_unit_pipe.sv | 125 ++++++++++++
 tb/tb_control_unit_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, ALU and
// operand-B select codes, the registered control word and the FSM state.
package cu_pkg;

    localparam int unsigned ALU_W = 4;
    localparam int unsigned SRC_W = 2;
    localparam int unsigned CTR_W = 4;

    // Opcodes (compared against the zero-extended opcode field)
    localparam int unsigned OP_ADD  = 'h00;
    localparam int unsigned OP_ADDI = 'h01;
    localparam int unsigned OP_SUB  = 'h02;
    localparam int unsigned OP_SUBI = 'h03;
    localparam int unsigned OP_XOR  = 'h04;
    localparam int unsigned OP_XORI = 'h05;
    localparam int unsigned OP_MULT = 'h06;
    localparam int unsigned OP_SLV  = 'h07;
    localparam int unsigned OP_SRV  = 'h08;
    localparam int unsigned OP_SCLV = 'h09;
    localparam int unsigned OP_SCRV = 'h0A;
    localparam int unsigned OP_LW   = 'h0B;
    localparam int unsigned OP_LWV  = 'h0C;
    localparam int unsigned OP_SW   = 'h0D;
    localparam int unsigned OP_SWV  = 'h0E;
    localparam int unsigned OP_JUMP = 'h0F;
    localparam int unsigned OP_BEQ  = 'h10;
    localparam int unsigned OP_NOP  = 'h3F;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_MULT = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_VADD = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_VSUB = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_VXOR = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLV  = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SRV  = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SCLV = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_SCRV = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_NONE = 4'b1111;

    // Operand-B select: register, bubble filler, sign-extended immediate, shift amount
    localparam logic [SRC_W-1:0] SRC_RD    = 2'b00;
    localparam logic [SRC_W-1:0] SRC_BUB   = 2'b01;
    localparam logic [SRC_W-1:0] SRC_SE    = 2'b10;
    localparam logic [SRC_W-1:0] SRC_SHIFT = 2'b11;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic [ALU_W-1:0] alu_control;
        logic [SRC_W-1:0] alu_src;
        logic             branch;
        logic             jump;
    } ctrl_word_t;

    localparam ctrl_word_t BUBBLE = '{
        reg_write:   1'b0,
        mem_to_reg:  1'b0,
        mem_write:   1'b0,
        alu_control: ALU_NONE,
        alu_src:     SRC_BUB,
        branch:      1'b0,
        jump:        1'b0
    };

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FLUSH = 2'b10
    } cu_state_t;

    // Control word for a register-writing ALU instruction
    function automatic ctrl_word_t alu_word(input logic [ALU_W-1:0] alu,
                                            input logic [SRC_W-1:0] src);
        ctrl_word_t w;
        w             = '0;
        w.reg_write   = 1'b1;
        w.alu_control = alu;
        w.alu_src     = src;
        return w;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder.
// Ports: op_i (opcode), vec_i (vector variant select) -> word_o (control word),
//        illegal_o (opcode undefined in this build).
// Vector support is compiled in only when CU_VECTOR_EN is defined.
module cu_decode
    import cu_pkg::*;
#(
    parameter int unsigned OP_W = 6
) (
    input  logic [OP_W-1:0] op_i,
    input  logic            vec_i,
    output ctrl_word_t      word_o,
    output logic            illegal_o
);

    logic vec_sel;

`ifdef CU_VECTOR_EN
    assign vec_sel = vec_i;
`else
    logic unused_vec;
    assign unused_vec = vec_i;
    assign vec_sel    = 1'b0;
`endif

    // Opcode table; unknown opcodes decode to a bubble and flag illegal
    always_comb begin
        word_o    = BUBBLE;
        illegal_o = 1'b0;
        case (32'(op_i))
            OP_ADD:  word_o = alu_word(vec_sel ? ALU_VADD : ALU_ADD, SRC_RD);
            OP_ADDI: word_o = alu_word(ALU_ADD, SRC_SE);
            OP_SUB:  word_o = alu_word(vec_sel ? ALU_VSUB : ALU_SUB, SRC_RD);
            OP_SUBI: word_o = alu_word(ALU_SUB, SRC_SE);
            OP_XOR:  word_o = alu_word(vec_sel ? ALU_VXOR : ALU_XOR, SRC_RD);
            OP_XORI: word_o = alu_word(ALU_XOR, SRC_SE);
            OP_MULT: word_o = alu_word(ALU_MULT, SRC_RD);
`ifdef CU_VECTOR_EN
            OP_SLV:  word_o = alu_word(ALU_SLV, SRC_SHIFT);
            OP_SRV:  word_o = alu_word(ALU_SRV, SRC_SHIFT);
            OP_SCLV: word_o = alu_word(ALU_SCLV, SRC_SHIFT);
            OP_SCRV: word_o = alu_word(ALU_SCRV, SRC_SHIFT);
            OP_LWV: begin
                word_o            = alu_word(ALU_ADD, SRC_RD);
                word_o.mem_to_reg = 1'b1;
            end
            OP_SWV: begin
                word_o           = alu_word(ALU_ADD, SRC_RD);
                word_o.reg_write = 1'b0;
                word_o.mem_write = 1'b1;
            end
`endif
            OP_LW: begin
                word_o            = alu_word(ALU_ADD, SRC_RD);
                word_o.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                word_o           = alu_word(ALU_ADD, SRC_RD);
                word_o.reg_write = 1'b0;
                word_o.mem_write = 1'b1;
            end
            OP_JUMP: begin
                word_o           = alu_word(ALU_ADD, SRC_RD);
                word_o.reg_write = 1'b0;
                word_o.jump      = 1'b1;
            end
            // Branch compare is a subtract of the two register operands
            OP_BEQ: begin
                word_o           = alu_word(ALU_SUB, SRC_RD);
                word_o.reg_write = 1'b0;
                word_o.branch    = 1'b1;
            end
            OP_NOP:  word_o = BUBBLE;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined control unit: decodes the instruction in the decode slot into a
// registered control word and sequences multi-cycle MULT stalls and
// jump/taken-branch flush windows.
// Ports: clk, rst (sync, active-high); OP, VEC, VALID_IN, STALL_EXT,
//        BRANCH_TAKEN in; registered control word bits, VALID_OUT, ILLEGAL out;
//        STALL/FLUSH out, decoded directly from the state.
// Build option: CU_VECTOR_EN enables the vector instructions (see cu_decode).
module control_unit_pipe
    import cu_pkg::*;
#(
    parameter int unsigned MULT_LAT  = 3,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned OP_W      = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] OP,
    input  logic            VEC,
    input  logic            VALID_IN,
    input  logic            STALL_EXT,
    input  logic            BRANCH_TAKEN,
    output logic            REG_WRITE,
    output logic            MEM_TO_REG,
    output logic            MEM_WRITE,
    output logic            BRANCH,
    output logic            JUMP,
    output logic [3:0]      ALU_CONTROL,
    output logic [1:0]      ALU_SRC,
    output logic            VALID_OUT,
    output logic            STALL,
    output logic            FLUSH,
    output logic            ILLEGAL
);

    cu_state_t        state_q;
    logic [CTR_W-1:0] cnt_q;
    ctrl_word_t       word_q;
    logic             valid_q;
    logic             illegal_q;

    ctrl_word_t       word_d;
    logic             illegal_d;
    logic             accept;
    logic             is_mult;
    logic             is_nop;

    cu_decode #(.OP_W(OP_W)) u_decode (
        .op_i      (OP),
        .vec_i     (VEC),
        .word_o    (word_d),
        .illegal_o (illegal_d)
    );

    assign STALL   = (state_q == ST_BUSY);
    assign FLUSH   = (state_q == ST_FLUSH);
    assign accept  = VALID_IN && !STALL && !STALL_EXT && (state_q == ST_RUN);
    assign is_mult = (32'(OP) == OP_MULT);
    assign is_nop  = (32'(OP) == OP_NOP);

    // FSM, stall/flush counter and output register; default is a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            word_q    <= BUBBLE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            word_q    <= BUBBLE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            if (BRANCH_TAKEN) begin
                // Taken branch overrides everything, including a same-cycle accept
                state_q <= ST_FLUSH;
                cnt_q   <= CTR_W'(FLUSH_CYC);
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (accept) begin
                            if (illegal_d) begin
                                illegal_q <= 1'b1;
                            end else begin
                                word_q  <= word_d;
                                valid_q <= !is_nop;
                                if (is_mult && (MULT_LAT > 1)) begin
                                    state_q <= ST_BUSY;
                                    cnt_q   <= CTR_W'(MULT_LAT - 1);
                                end else if (word_d.jump) begin
                                    state_q <= ST_FLUSH;
                                    cnt_q   <= CTR_W'(FLUSH_CYC);
                                end
                            end
                        end
                    end
                    ST_BUSY, ST_FLUSH: begin
                        // Downstream stall freezes the count
                        if (!STALL_EXT) begin
                            if (cnt_q <= CTR_W'(1)) begin
                                state_q <= ST_RUN;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q - CTR_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign REG_WRITE   = word_q.reg_write;
    assign MEM_TO_REG  = word_q.mem_to_reg;
    assign MEM_WRITE   = word_q.mem_write;
    assign ALU_CONTROL = word_q.alu_control;
    assign ALU_SRC     = word_q.alu_src;
    assign BRANCH      = word_q.branch;
    assign JUMP        = word_q.jump;
    assign VALID_OUT   = valid_q;
    assign ILLEGAL     = illegal_q;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Testbench for control_unit_pipe: directed scenarios plus a randomized run
// checked against a cycle-level reference model built from the opcode table.
module tb_control_unit_pipe;

    localparam int unsigned MULT_LAT  = 3;
    localparam int unsigned FLUSH_CYC = 2;
    localparam logic [10:0] BUB       = 11'b000_1111_01_00;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OP;
    logic       VEC, VALID_IN, STALL_EXT, BRANCH_TAKEN;
    logic       REG_WRITE, MEM_TO_REG, MEM_WRITE, BRANCH, JUMP;
    logic [3:0] ALU_CONTROL;
    logic [1:0] ALU_SRC;
    logic       VALID_OUT, STALL, FLUSH, ILLEGAL;

    int checks = 0;
    int errors = 0;

    // Reference model state: remaining stall / flush cycles and expected outputs
    int          m_busy, m_flush;
    logic [10:0] m_word, m_care;
    logic        m_valid, m_ill;

    control_unit_pipe #(.MULT_LAT(MULT_LAT), .FLUSH_CYC(FLUSH_CYC), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .OP(OP), .VEC(VEC), .VALID_IN(VALID_IN),
        .STALL_EXT(STALL_EXT), .BRANCH_TAKEN(BRANCH_TAKEN),
        .REG_WRITE(REG_WRITE), .MEM_TO_REG(MEM_TO_REG), .MEM_WRITE(MEM_WRITE),
        .BRANCH(BRANCH), .JUMP(JUMP), .ALU_CONTROL(ALU_CONTROL), .ALU_SRC(ALU_SRC),
        .VALID_OUT(VALID_OUT), .STALL(STALL), .FLUSH(FLUSH), .ILLEGAL(ILLEGAL)
    );

    always #5 clk = ~clk;

    // {word(11), VALID_OUT, STALL, FLUSH, ILLEGAL}
    wire [14:0] obs = {REG_WRITE, MEM_TO_REG, MEM_WRITE, ALU_CONTROL, ALU_SRC,
                       BRANCH, JUMP, VALID_OUT, STALL, FLUSH, ILLEGAL};

    // Opcode table: word = {RW, M2R, MW, ALU[3:0], SRC[1:0], BR, J}
    function automatic void ref_decode(input logic [5:0] op, input logic vec,
                                       output logic [10:0] w, output logic [10:0] care,
                                       output logic legal, output logic nop);
        logic ven, v;
`ifdef CU_VECTOR_EN
        ven = 1'b1;
`else
        ven = 1'b0;
`endif
        v = vec & ven;
        w = BUB; care = '1; legal = 1'b1; nop = 1'b0;
        case (op)
            6'h00: w = {3'b100, (v ? 4'b0100 : 4'b0000), 2'b00, 2'b00};
            6'h01: w = {3'b100, 4'b0000, 2'b10, 2'b00};
            6'h02: w = {3'b100, (v ? 4'b0101 : 4'b0001), 2'b00, 2'b00};
            6'h03: w = {3'b100, 4'b0001, 2'b10, 2'b00};
            6'h04: w = {3'b100, (v ? 4'b0110 : 4'b0011), 2'b00, 2'b00};
            6'h05: w = {3'b100, 4'b0011, 2'b10, 2'b00};
            6'h06: w = {3'b100, 4'b0010, 2'b00, 2'b00};
            6'h07: if (ven) w = {3'b100, 4'b0111, 2'b11, 2'b00}; else legal = 1'b0;
            6'h08: if (ven) w = {3'b100, 4'b1000, 2'b11, 2'b00}; else legal = 1'b0;
            6'h09: if (ven) w = {3'b100, 4'b1001, 2'b11, 2'b00}; else legal = 1'b0;
            6'h0A: if (ven) w = {3'b100, 4'b1010, 2'b11, 2'b00}; else legal = 1'b0;
            6'h0B: w = {3'b110, 4'b0000, 2'b00, 2'b00};
            6'h0C: if (ven) w = {3'b110, 4'b0000, 2'b00, 2'b00}; else legal = 1'b0;
            6'h0D: w = {3'b001, 4'b0000, 2'b00, 2'b00};
            6'h0E: if (ven) w = {3'b001, 4'b0000, 2'b00, 2'b00}; else legal = 1'b0;
            // Only the enable/branch/jump bits are defined for control transfers
            6'h0F: begin w = 11'b000_0000_00_01; care = 11'b111_0000_00_11; end
            6'h10: begin w = 11'b000_0000_00_10; care = 11'b111_0000_00_11; end
            6'h3F: nop = 1'b1;
            default: legal = 1'b0;
        endcase
    endfunction

    // Advance the model on the current inputs, then clock the DUT
    task automatic tick();
        logic [10:0] w, c;
        logic lg, np;
        ref_decode(OP, VEC, w, c, lg, np);
        m_word = BUB; m_care = '1; m_valid = 1'b0; m_ill = 1'b0;
        if (rst) begin
            m_busy = 0; m_flush = 0;
        end else if (BRANCH_TAKEN) begin
            m_busy = 0; m_flush = FLUSH_CYC;
        end else if (m_busy > 0 || m_flush > 0) begin
            if (!STALL_EXT) begin
                if (m_busy > 0) m_busy--; else m_flush--;
            end
        end else if (VALID_IN && !STALL_EXT) begin
            if (!lg) m_ill = 1'b1;
            else begin
                m_word = w; m_care = c; m_valid = !np;
                if (OP == 6'h06) m_busy = MULT_LAT - 1;
                if (OP == 6'h0F) m_flush = FLUSH_CYC;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; VALID_IN = 1'b0; BRANCH_TAKEN = 1'b0; STALL_EXT = 1'b0;
        VEC = 1'b0; OP = 6'h3F;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== {BUB, 4'b0000}) begin
            errors++; $display("FAIL reset: got %b want %b", obs, {BUB, 4'b0000});
        end
    endtask

    task automatic test_addi();
        do_reset();
        OP = 6'h01; VALID_IN = 1'b1; tick(); VALID_IN = 1'b0;
        checks++;
        if (obs !== {11'b100_0000_10_00, 4'b1000}) begin
            errors++; $display("FAIL addi: got %b want %b", obs, {11'b100_0000_10_00, 4'b1000});
        end
    endtask

    task automatic test_mult();
        logic [14:0] exp [4];
        exp[0] = {11'b100_0010_00_00, 4'b1100};
        exp[1] = {BUB, 4'b0100};
        exp[2] = {BUB, 4'b0000};
        exp[3] = {11'b100_0000_10_00, 4'b1000};
        do_reset();
        OP = 6'h06; VALID_IN = 1'b1; tick();
        OP = 6'h01;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL mult[%0d]: got %b want %b", i, obs, exp[i]);
            end
            if (i < 3) tick();
        end
        VALID_IN = 1'b0;
    endtask

    task automatic test_jump();
        logic [14:0] exp [3];
        exp[0] = {BUB, 4'b0010};
        exp[1] = {BUB, 4'b0000};
        exp[2] = {11'b100_0000_00_00, 4'b1000};
        do_reset();
        OP = 6'h0F; VALID_IN = 1'b1; tick();
        checks++;
        if ({JUMP, BRANCH, REG_WRITE, VALID_OUT, STALL, FLUSH} !== 6'b100101) begin
            errors++; $display("FAIL jump: got %b want 100101",
                               {JUMP, BRANCH, REG_WRITE, VALID_OUT, STALL, FLUSH});
        end
        OP = 6'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL jump_win[%0d]: got %b want %b", i, obs, exp[i]);
            end
        end
        VALID_IN = 1'b0;
    endtask

    task automatic test_branch_busy();
        logic br_seq [6];
        logic [14:0] exp [6];
        br_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp[0] = {BUB, 4'b0010}; exp[1] = {BUB, 4'b0010};
        exp[2] = {BUB, 4'b0010}; exp[3] = {BUB, 4'b0010};
        exp[4] = {BUB, 4'b0000}; exp[5] = {11'b100_0000_00_00, 4'b1000};
        do_reset();
        OP = 6'h06; VALID_IN = 1'b1; tick();
        checks++;
        if (STALL !== 1'b1) begin
            errors++; $display("FAIL br_busy_stall: got %b want 1", STALL);
        end
        OP = 6'h00;
        for (int i = 0; i < 6; i++) begin
            BRANCH_TAKEN = br_seq[i];
            tick();
            checks++;
            if (obs !== exp[i]) begin
                errors++; $display("FAIL br_flush[%0d]: got %b want %b", i, obs, exp[i]);
            end
        end
        BRANCH_TAKEN = 1'b0; VALID_IN = 1'b0;
    endtask

    task automatic test_illegal();
        logic [14:0] e07, eadd;
`ifdef CU_VECTOR_EN
        e07  = {11'b100_0111_11_00, 4'b1000};
        eadd = {11'b100_0100_00_00, 4'b1000};
`else
        e07  = {BUB, 4'b0001};
        eadd = {11'b100_0000_00_00, 4'b1000};
`endif
        do_reset();
        OP = 6'h2A; VALID_IN = 1'b1; tick();
        checks++;
        if (obs !== {BUB, 4'b0001}) begin
            errors++; $display("FAIL illegal_2a: got %b want %b", obs, {BUB, 4'b0001});
        end
        VALID_IN = 1'b0; tick();
        checks++;
        if (obs !== {BUB, 4'b0000}) begin
            errors++; $display("FAIL illegal_pulse: got %b want %b", obs, {BUB, 4'b0000});
        end
        OP = 6'h07; VALID_IN = 1'b1; tick();
        checks++;
        if (obs !== e07) begin
            errors++; $display("FAIL op07: got %b want %b", obs, e07);
        end
        OP = 6'h00; VEC = 1'b1; tick();
        checks++;
        if (obs !== eadd) begin
            errors++; $display("FAIL add_vec: got %b want %b", obs, eadd);
        end
        VEC = 1'b0; VALID_IN = 1'b0;
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        OP = 6'h0F; VALID_IN = 1'b1; tick();
        VALID_IN = 1'b0; rst = 1'b1; tick();
        checks++;
        if (obs !== {BUB, 4'b0000}) begin
            errors++; $display("FAIL rst_flush: got %b want %b", obs, {BUB, 4'b0000});
        end
        rst = 1'b0; OP = 6'h01; VALID_IN = 1'b1; tick();
        checks++;
        if (obs !== {11'b100_0000_10_00, 4'b1000}) begin
            errors++; $display("FAIL rst_flush_resume: got %b want %b",
                               obs, {11'b100_0000_10_00, 4'b1000});
        end
        VALID_IN = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0] ops [18];
        logic [14:0] exp, care;
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h3F};
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rst          = ($urandom % 64) == 0;
            BRANCH_TAKEN = ($urandom % 12) == 0;
            STALL_EXT    = ($urandom % 5) == 0;
            VALID_IN     = ($urandom % 4) != 0;
            VEC          = $urandom % 2;
            OP           = (($urandom % 5) == 0) ? 6'($urandom % 64) : ops[$urandom % 18];
            tick();
            exp  = {m_word, m_valid, (m_busy > 0), (m_flush > 0), m_ill};
            care = {m_care, 4'hF};
            checks++;
            if ((obs & care) !== (exp & care)) begin
                errors++; $display("FAIL random[%0d]: got %b want %b care %b", i, obs, exp, care);
            end
        end
        rst = 1'b0; BRANCH_TAKEN = 1'b0; STALL_EXT = 1'b0; VALID_IN = 1'b0;
    endtask

    initial begin
        m_busy = 0; m_flush = 0;
        test_reset();
        test_addi();
        test_mult();
        test_jump();
        test_branch_busy();
        test_illegal();
        test_reset_mid_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
